// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if: request/response bundle for the shared barrel shifter.
// Ports (slave = arbiter view):
//   req0_* / req1_*  valid, data[31:0], amt[4:0], type[1:0], tag[TAG_W-1:0] in; ready out
//   rsp_*            valid, data[31:0], port, tag out; ready in
interface shift_arbiter_if #(
    parameter int TAG_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [31:0]      req0_data;
    logic [4:0]       req0_amt;
    logic [1:0]       req0_type;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid;
    logic             req1_ready;
    logic [31:0]      req1_data;
    logic [4:0]       req1_amt;
    logic [1:0]       req1_type;
    logic [TAG_W-1:0] req1_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_port;
    logic [TAG_W-1:0] rsp_tag;

    modport slave (
        input  req0_valid, req0_data, req0_amt, req0_type, req0_tag,
        input  req1_valid, req1_data, req1_amt, req1_type, req1_tag,
        input  rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_port, rsp_tag
    );

    modport master (
        output req0_valid, req0_data, req0_amt, req0_type, req0_tag,
        output req1_valid, req1_data, req1_amt, req1_type, req1_tag,
        output rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_port, rsp_tag
    );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin sharing of one 32-bit barrel shifter between two requesters.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   flush                drops the held result and blocks grants for the cycle
//   bus (slave)          two request channels and one registered response channel
//   perf_cnt0/perf_cnt1  saturating per-port grant counters
module shift_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    shift_arbiter_if.slave       bus,
    output logic [15:0]          perf_cnt0,
    output logic [15:0]          perf_cnt1
);
    logic             rr;
    logic             rv;
    logic [31:0]      rd;
    logic             rp;
    logic [TAG_W-1:0] rt;
    logic [15:0]      cnt0;
    logic [15:0]      cnt1;
    logic             acc;
    logic             g0;
    logic             g1;
    logic [31:0]      d;
    logic [4:0]       a;
    logic [1:0]       t;
    logic [TAG_W-1:0] tg;
    logic [31:0]      sra;
    logic [31:0]      res;

    // rst gates acceptance so readies drop while reset is held
    assign acc = (!rv | bus.rsp_ready) & !flush & !rst;
    assign g0  = acc & bus.req0_valid & (!bus.req1_valid | !rr);
    assign g1  = acc & bus.req1_valid & (!bus.req0_valid | rr);

    assign d  = g1 ? bus.req1_data : bus.req0_data;
    assign a  = g1 ? bus.req1_amt  : bus.req0_amt;
    assign t  = g1 ? bus.req1_type : bus.req0_type;
    assign tg = g1 ? bus.req1_tag  : bus.req0_tag;

    // kept as its own assignment so the unsigned mux below cannot strip the sign
    assign sra = $signed(d) >>> a;
    assign res = t == 2'b00 ? d << a : t == 2'b01 ? d >> a : sra;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr   <= 1'b0;
            rv   <= 1'b0;
            rd   <= '0;
            rp   <= 1'b0;
            rt   <= '0;
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (g0 | g1) begin
                rv <= 1'b1;
                rd <= res;
                rp <= g1;
                rt <= tg;
                rr <= ~g1;
            end else if (flush | bus.rsp_ready) begin
                rv <= 1'b0;
            end
            if (g0 && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
            if (g1 && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
        end
    end

    assign bus.req0_ready = g0;
    assign bus.req1_ready = g1;
    assign bus.rsp_valid  = rv;
    assign bus.rsp_data   = rd;
    assign bus.rsp_port   = rp;
    assign bus.rsp_tag    = rt;
    assign perf_cnt0      = cnt0;
    assign perf_cnt1      = cnt1;
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: scoreboard bench for shift_arbiter with directed vectors.
module tb_shift_arbiter;
    localparam int TW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [15:0] perf_cnt0;
    logic [15:0] perf_cnt1;
    int          total = 0;
    int          bad = 0;
    int          n;

    typedef struct {
        logic [31:0]   d;
        logic          p;
        logic [TW-1:0] t;
    } exp_t;
    exp_t q[$];

    shift_arbiter_if #(.TAG_W(TW)) bus();

    shift_arbiter #(.TAG_W(TW)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .bus(bus),
        .perf_cnt0(perf_cnt0),
        .perf_cnt1(perf_cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit p, input logic [31:0] d, input logic [4:0] a,
                         input logic [1:0] ty, input logic [TW-1:0] tg);
        if (p) begin
            bus.req1_data = d; bus.req1_amt = a; bus.req1_type = ty; bus.req1_tag = tg;
            bus.req1_valid = 1'b1;
        end else begin
            bus.req0_data = d; bus.req0_amt = a; bus.req0_type = ty; bus.req0_tag = tg;
            bus.req0_valid = 1'b1;
        end
    endtask

    // waits for the grant on port p, records the expected response, drops valid after the edge
    task automatic wait_grant(input bit p, input logic [31:0] ed, input logic [TW-1:0] tg,
                              output int cyc);
        bit got = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            cyc = i;
            got = p ? bus.req1_ready : bus.req0_ready;
        end
        chk("grant_seen", 32'(got), 32'd1);
        if (got) q.push_back('{ed, p, tg});
        @(posedge clk);
        #1;
        if (p) bus.req1_valid = 1'b0;
        else bus.req0_valid = 1'b0;
    endtask

    task automatic issue(input bit p, input logic [31:0] d, input logic [4:0] a,
                         input logic [1:0] ty, input logic [TW-1:0] tg,
                         input logic [31:0] ed, output int cyc);
        drive(p, d, a, ty, tg);
        wait_grant(p, ed, tg, cyc);
    endtask

    // monitor: a result leaves when valid & ready at the coming edge; a flush drops it unchecked
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid) begin
            if (flush) begin
                if (q.size() != 0) void'(q.pop_front());
            end else if (bus.rsp_ready) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rsp_data", bus.rsp_data, e.d);
                    chk("rsp_port", 32'(bus.rsp_port), 32'(e.p));
                    chk("rsp_tag", 32'(bus.rsp_tag), 32'(e.t));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req0_valid = 1'b1; bus.req0_data = '0; bus.req0_amt = '0; bus.req0_type = '0; bus.req0_tag = '0;
        bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_amt = '0; bus.req1_type = '0; bus.req1_tag = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_data", bus.rsp_data, 32'd0);
        chk("rst_port", 32'(bus.rsp_port), 32'd0);
        chk("rst_tag", 32'(bus.rsp_tag), 32'd0);
        chk("rst_perf0", 32'(perf_cnt0), 32'd0);
        chk("rst_perf1", 32'(perf_cnt1), 32'd0);
        chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
        bus.req0_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        issue(1'b0, 32'h8000_0001, 5'd4, 2'b11, 4'd3, 32'hF800_0000, n);
        chk("t1_latency", 32'(n), 32'd1);
        chk("t1_valid", 32'(bus.rsp_valid), 32'd1);
        chk("t1_perf0", 32'(perf_cnt0), 32'd1);

        issue(1'b1, 32'hA5A5_0F0F, 5'd0, 2'b01, 4'd4, 32'hA5A5_0F0F, n);

        drive(1'b0, 32'h1234_5678, 5'd4, 2'b01, 4'd1);
        drive(1'b1, 32'h0000_00FF, 5'd8, 2'b00, 4'd2);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("alt_ready0", 32'(bus.req0_ready), 32'(i % 2 == 0));
            chk("alt_ready1", 32'(bus.req1_ready), 32'(i % 2 == 1));
            if (i % 2 == 0) q.push_back('{32'h0123_4567, 1'b0, 4'd1});
            else q.push_back('{32'h0000_FF00, 1'b1, 4'd2});
        end
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("alt_perf0", 32'(perf_cnt0), 32'd4);
        chk("alt_perf1", 32'(perf_cnt1), 32'd4);

        issue(1'b0, 32'hF0F0_F0F0, 5'd0, 2'b00, 4'd5, 32'hF0F0_F0F0, n);
        bus.rsp_ready = 1'b0;
        drive(1'b0, 32'h8000_0000, 5'd31, 2'b10, 4'd6);
        drive(1'b1, 32'h8000_0000, 5'd31, 2'b01, 4'd7);
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready0", 32'(bus.req0_ready), 32'd0);
            chk("bp_ready1", 32'(bus.req1_ready), 32'd0);
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_data", bus.rsp_data, 32'hF0F0_F0F0);
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        wait_grant(1'b1, 32'h0000_0001, 4'd7, n);
        chk("bp_rr_held", 32'(n), 32'd1);
        wait_grant(1'b0, 32'hFFFF_FFFF, 4'd6, n);
        chk("bp_next", 32'(n), 32'd1);

        issue(1'b0, 32'h1234_5678, 5'd0, 2'b11, 4'd8, 32'h1234_5678, n);
        flush = 1'b1;
        drive(1'b1, 32'h0000_00FF, 5'd8, 2'b00, 4'd9);
        @(negedge clk);
        chk("fl_ready1", 32'(bus.req1_ready), 32'd0);
        chk("fl_held", 32'(bus.rsp_valid), 32'd1);
        @(posedge clk);
        #1 flush = 1'b0;
        chk("fl_cleared", 32'(bus.rsp_valid), 32'd0);
        wait_grant(1'b1, 32'h0000_FF00, 4'd9, n);
        chk("fl_regrant", 32'(n), 32'd1);

        @(negedge clk);
        force dut.cnt0 = 16'hFFFE;
        #1 release dut.cnt0;
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 32'h0000_0001, 5'd31, 2'b00, 4'hA, 32'h8000_0000, n);
            chk("sat_perf0", 32'(perf_cnt0), 32'h0000_FFFF);
        end

        bus.rsp_ready = 1'b0;
        drive(1'b1, 32'h0000_0F00, 5'd4, 2'b00, 4'd2);
        @(negedge clk);
        chk("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("arst_data", bus.rsp_data, 32'd0);
        chk("arst_port", 32'(bus.rsp_port), 32'd0);
        chk("arst_tag", 32'(bus.rsp_tag), 32'd0);
        chk("arst_perf0", 32'(perf_cnt0), 32'd0);
        chk("arst_perf1", 32'(perf_cnt1), 32'd0);
        chk("arst_ready1", 32'(bus.req1_ready), 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
